// File: rtl/s2i_unpack.sv
// s2i_unpack: re-formats S-format rs1/imm fields into I-format fields (m, rd, rs1, imm)
//    through a 2-entry valid/ready FIFO.
//    Optional macro S2I_BYPASS_EN: when the FIFO is empty and out_ready is high, the
//    input passes straight to the output with no latency.
//    Ports:
//       clk, rst_n                      clock, synchronous active-low reset
//       in_valid/in_ready               producer handshake
//       in_rs1, in_imm, in_lsb          S-format fields plus the restored imm bit 0
//       out_valid/out_ready             consumer handshake
//       out_m, out_rd, out_rs1, out_imm I-format fields of the head entry
//       conv_cnt                        wrapping count of output handshakes
module s2i_unpack #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_rs1,
   input  logic [7:0]       in_imm,
   input  logic             in_lsb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_m,
   output logic [2:0]       out_rd,
   output logic [2:0]       out_rs1,
   output logic [4:0]       out_imm,
   output logic [CNT_W-1:0] conv_cnt
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   state_t           state_q, state_d;
   logic [11:0]      mem_q [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [11:0]      in_map, head;
   logic             byp, push, pop;
   // entries hold the already-mapped {m, rd, rs1, imm}
   assign in_map = {in_rs1, in_imm, in_lsb};
   // empty FIFO shows zeros so the output fields read 0 out of reset
   assign head = (state_q == EMPTY) ? 12'd0 : mem_q[rd_ptr_q];
   assign in_ready = rst_n && (state_q != FULL);
`ifdef S2I_BYPASS_EN
   assign byp = (state_q == EMPTY) && out_ready;
   assign out_valid = byp ? in_valid : (state_q != EMPTY);
   assign {out_m, out_rd, out_rs1, out_imm} = byp ? in_map : head;
`else
   assign byp = 1'b0;
   assign out_valid = (state_q != EMPTY);
   assign {out_m, out_rd, out_rs1, out_imm} = head;
`endif
   // a bypassed transfer is both push and pop, so it never touches the FIFO
   assign push = in_valid && in_ready && !byp;
   assign pop  = out_valid && out_ready && !byp;
   assign conv_cnt = cnt_q;
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   state_d = push ? ONE : EMPTY;
         ONE:     state_d = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
         FULL:    state_d = pop ? ONE : FULL;
         default: state_d = EMPTY;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (push) begin
            mem_q[wr_ptr_q] <= in_map;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         if (out_valid && out_ready) cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_s2i_unpack.sv
// tb_s2i_unpack: directed and random checks of s2i_unpack against a queue-based model
module tb_s2i_unpack;
   logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, in_lsb = 0;
   logic [2:0] in_rs1 = 0;
   logic [7:0] in_imm = 0;
   logic       in_ready, out_valid, out_m;
   logic [2:0] out_rd, out_rs1;
   logic [4:0] out_imm;
   logic [7:0] conv_cnt;
   int         tests = 0, fails = 0;
   logic [11:0] q[$];
   logic [7:0]  cnt_m = 0;
   bit          byp_en;

   s2i_unpack #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_imm(in_imm), .in_lsb(in_lsb), .out_valid(out_valid),
      .out_ready(out_ready), .out_m(out_m), .out_rd(out_rd), .out_rs1(out_rs1),
      .out_imm(out_imm), .conv_cnt(conv_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] fmap(input logic [2:0] r, input logic [7:0] i, input logic l);
      int m, rd, rs, im;
      m  = r / 4;
      rd = (r % 4) * 2 + i / 128;
      rs = (i / 16) % 8;
      im = (i % 16) * 2 + l;
      return {m[0], rd[2:0], rs[2:0], im[4:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_byp();
      return byp_en && q.size() == 0 && out_ready;
   endfunction

   function automatic bit model_ov();
      return model_byp() ? in_valid : (q.size() > 0);
   endfunction

   task automatic check_outs(input string tag);
      logic [11:0] f;
      #1;
      f = model_byp() ? fmap(in_rs1, in_imm, in_lsb) : (q.size() > 0 ? q[0] : 12'd0);
      chk({tag, ".in_ready"}, in_ready, rst_n && q.size() < 2);
      chk({tag, ".out_valid"}, out_valid, model_ov());
      if (model_ov()) chk({tag, ".fields"}, {out_m, out_rd, out_rs1, out_imm}, f);
      chk({tag, ".conv_cnt"}, conv_cnt, cnt_m);
   endtask

   task automatic cycle();
      bit byp, ov, ir;
      byp = model_byp();
      ov  = model_ov();
      ir  = rst_n && q.size() < 2;
      if (!rst_n) begin
         q.delete();
         cnt_m = 0;
      end else begin
         if (ov && out_ready) begin
            cnt_m++;
            if (!byp) void'(q.pop_front());
         end
         if (in_valid && ir && !byp) q.push_back(fmap(in_rs1, in_imm, in_lsb));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] r, input logic [7:0] i, input logic l);
      in_valid = v; in_rs1 = r; in_imm = i; in_lsb = l;
   endtask

   initial begin
`ifdef S2I_BYPASS_EN
      byp_en = 1;
`else
      byp_en = 0;
`endif
      // reset held with a pending input
      drive(1, 3'b101, 8'hff, 1);
      rst_n = 0;
      repeat (3) cycle();
      #1;
      chk("rst.out_valid", out_valid, 0);
      chk("rst.conv_cnt", conv_cnt, 0);
      chk("rst.in_ready", in_ready, 0);
      chk("rst.fields", {out_m, out_rd, out_rs1, out_imm}, 0);
      rst_n = 1;
      drive(0, 0, 0, 0);
      check_outs("rel");
      // single conversion
      drive(1, 3'b110, 8'b10101100, 1);
      cycle();
      drive(0, 0, 0, 0);
      #1;
      chk("single.out_valid", out_valid, 1);
      chk("single.fields", {out_m, out_rd, out_rs1, out_imm}, 12'b1_101_010_11001);
      out_ready = 1;
      check_outs("single.pop");
      cycle();
      out_ready = 0;
      #1;
      chk("single.cnt", conv_cnt, 1);
      // back-pressure to FULL
      drive(1, 3'b111, 8'b10110011, 0);
      cycle();
      drive(1, 3'b000, 8'b00000000, 0);
      cycle();
      drive(0, 0, 0, 0);
      #1;
      chk("bp.in_ready", in_ready, 0);
      chk("bp.out_valid", out_valid, 1);
      out_ready = 1;
      #1;
      chk("bp.first", {out_m, out_rd, out_rs1, out_imm}, 12'b1_111_011_00110);
      cycle();
      chk("bp.second", {out_m, out_rd, out_rs1, out_imm}, 0);
      chk("bp.second_valid", out_valid, 1);
      chk("bp.ready_back", in_ready, 1);
      cycle();
      check_outs("bp.drained");
      chk("bp.cnt", conv_cnt, 3);
      // streaming from a fresh reset so the count ends at 300 mod 256
      rst_n = 0;
      cycle();
      rst_n = 1;
      out_ready = 1;
      for (int n = 0; n < 300; n++) begin
         drive(1, 3'($urandom), 8'($urandom), 1'($urandom));
         check_outs("stream");
         if (n > 0) chk("stream.no_bubble", out_valid, 1);
         cycle();
      end
      drive(0, 0, 0, 0);
      check_outs("stream.tail");
      cycle();
      check_outs("stream.end");
      chk("stream.cnt44", conv_cnt, 44);
      // reset while FULL with a pending handshake
      out_ready = 0;
      drive(1, 3'b011, 8'h5a, 1);
      cycle();
      drive(1, 3'b100, 8'ha5, 0);
      cycle();
      check_outs("mid.full");
      rst_n = 0;
      out_ready = 1;
      cycle();
      rst_n = 1;
      drive(0, 0, 0, 0);
      #1;
      chk("mid.out_valid", out_valid, 0);
      chk("mid.cnt", conv_cnt, 0);
      repeat (3) begin
         check_outs("mid.after");
         cycle();
      end
      // empty with out_ready high: zero latency only in the bypass build
      drive(1, 3'b110, 8'b10101100, 1);
      #1;
      chk("byp.out_valid", out_valid, byp_en);
      if (byp_en) chk("byp.fields", {out_m, out_rd, out_rs1, out_imm}, 12'b1_101_010_11001);
      cycle();
      drive(0, 0, 0, 0);
      check_outs("byp.next");
      cycle();
      check_outs("byp.done");
      // random traffic
      for (int n = 0; n < 400; n++) begin
         out_ready = 1'($urandom_range(0, 3) != 0);
         drive(1'($urandom_range(0, 2) != 0), 3'($urandom), 8'($urandom), 1'($urandom));
         check_outs("rand");
         cycle();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
